time_counter: RTL and testbench

- Current-time register stage directly downstream of the time generator.
- Consumes the one-minute pulse and keeps the current time of day as four BCD digits, 24-hour format, HH:MM.
- Accepts a synchronous load of a user-set time from the alarm controller, with range checking.
- Emits a one-cycle midnight-rollover pulse.
- Outputs feed the display driver and the alarm comparator.

---
 rtl/time_counter.sv | 158 +++++++++++++++
 tb/tb_time_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// Current time of day as four BCD digits (HH:MM, 24 h), with range-checked load and a midnight pulse.
// Optional seconds digits are enabled by defining TIME_COUNTER_SECONDS_EN.
module time_counter #(
  parameter int unsigned MAX_HOUR = 23,
  parameter int unsigned MAX_MIN  = 59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_minute,
`ifdef TIME_COUNTER_SECONDS_EN
  input  logic       one_second,
  output logic [3:0] ms_sec,
  output logic [3:0] ls_sec,
`endif
  input  logic       load_new_c,
  input  logic [3:0] new_ms_hr,
  input  logic [3:0] new_ls_hr,
  input  logic [3:0] new_ms_min,
  input  logic [3:0] new_ls_min,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic       day_tick,
  output logic       load_err
);

  if (MAX_HOUR < 1 || MAX_HOUR > 23 || MAX_MIN < 1 || MAX_MIN > 59) begin : g_bad_param
    $error("time_counter: MAX_HOUR must be 1..23 and MAX_MIN 1..59");
  end

  localparam logic [7:0] MaxHour = 8'(MAX_HOUR);
  localparam logic [7:0] MaxMin  = 8'(MAX_MIN);

  logic [3:0] ms_hr_q, ms_hr_d;
  logic [3:0] ls_hr_q, ls_hr_d;
  logic [3:0] ms_min_q, ms_min_d;
  logic [3:0] ls_min_q, ls_min_d;
  logic       day_tick_q, day_tick_d;
  logic       load_err_q, load_err_d;

  logic [7:0] cur_hour, cur_min;
  logic [7:0] new_hour, new_min;
  logic       load_ok;

  // Binary views of the BCD digits for range comparisons.
  always_comb begin
    cur_hour = {4'b0000, ms_hr_q} * 8'd10 + {4'b0000, ls_hr_q};
    cur_min  = {4'b0000, ms_min_q} * 8'd10 + {4'b0000, ls_min_q};
    new_hour = {4'b0000, new_ms_hr} * 8'd10 + {4'b0000, new_ls_hr};
    new_min  = {4'b0000, new_ms_min} * 8'd10 + {4'b0000, new_ls_min};
    load_ok  = (new_ms_hr <= 4'd9) && (new_ls_hr <= 4'd9) &&
               (new_ms_min <= 4'd5) && (new_ls_min <= 4'd9) &&
               (new_hour <= MaxHour) && (new_min <= MaxMin);
  end

  always_comb begin
    ms_hr_d    = ms_hr_q;
    ls_hr_d    = ls_hr_q;
    ms_min_d   = ms_min_q;
    ls_min_d   = ls_min_q;
    day_tick_d = 1'b0;
    load_err_d = 1'b0;

    if (load_new_c) begin
      // A coincident one_minute is intentionally discarded.
      if (load_ok) begin
        ms_hr_d  = new_ms_hr;
        ls_hr_d  = new_ls_hr;
        ms_min_d = new_ms_min;
        ls_min_d = new_ls_min;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (one_minute) begin
      if (cur_min >= MaxMin) begin
        ms_min_d = 4'd0;
        ls_min_d = 4'd0;
        if (cur_hour >= MaxHour) begin
          ms_hr_d    = 4'd0;
          ls_hr_d    = 4'd0;
          day_tick_d = 1'b1;
        end else if (ls_hr_q >= 4'd9) begin
          ls_hr_d = 4'd0;
          ms_hr_d = ms_hr_q + 4'd1;
        end else begin
          ls_hr_d = ls_hr_q + 4'd1;
        end
      end else if (ls_min_q >= 4'd9) begin
        ls_min_d = 4'd0;
        ms_min_d = ms_min_q + 4'd1;
      end else begin
        ls_min_d = ls_min_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms_hr_q    <= 4'd0;
      ls_hr_q    <= 4'd0;
      ms_min_q   <= 4'd0;
      ls_min_q   <= 4'd0;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ms_hr_q    <= ms_hr_d;
      ls_hr_q    <= ls_hr_d;
      ms_min_q   <= ms_min_d;
      ls_min_q   <= ls_min_d;
      day_tick_q <= day_tick_d;
      load_err_q <= load_err_d;
    end
  end

  assign ms_hr    = ms_hr_q;
  assign ls_hr    = ls_hr_q;
  assign ms_min   = ms_min_q;
  assign ls_min   = ls_min_q;
  assign day_tick = day_tick_q;
  assign load_err = load_err_q;

`ifdef TIME_COUNTER_SECONDS_EN
  logic [3:0] ms_sec_q, ms_sec_d;
  logic [3:0] ls_sec_q, ls_sec_d;

  // Seconds restart on every minute pulse and every load; they never carry into minutes.
  always_comb begin
    ms_sec_d = ms_sec_q;
    ls_sec_d = ls_sec_q;
    if (load_new_c || one_minute) begin
      ms_sec_d = 4'd0;
      ls_sec_d = 4'd0;
    end else if (one_second) begin
      if (ls_sec_q >= 4'd9) begin
        ls_sec_d = 4'd0;
        ms_sec_d = (ms_sec_q >= 4'd5) ? 4'd0 : ms_sec_q + 4'd1;
      end else begin
        ls_sec_d = ls_sec_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms_sec_q <= 4'd0;
      ls_sec_q <= 4'd0;
    end else begin
      ms_sec_q <= ms_sec_d;
      ls_sec_q <= ls_sec_d;
    end
  end

  assign ms_sec = ms_sec_q;
  assign ls_sec = ls_sec_q;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: directed scenarios plus random traffic against a
// minutes-since-midnight reference model.
module tb_time_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_minute = 1'b0;
  logic       load_new_c = 1'b0;
  logic [3:0] new_ms_hr = 4'd0;
  logic [3:0] new_ls_hr = 4'd0;
  logic [3:0] new_ms_min = 4'd0;
  logic [3:0] new_ls_min = 4'd0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       day_tick, load_err;
`ifdef TIME_COUNTER_SECONDS_EN
  logic       one_second = 1'b0;
  logic [3:0] ms_sec, ls_sec;
`endif

  always #5 clock = ~clock;

  time_counter dut (
    .clock      (clock),
    .reset      (reset),
    .one_minute (one_minute),
`ifdef TIME_COUNTER_SECONDS_EN
    .one_second (one_second),
    .ms_sec     (ms_sec),
    .ls_sec     (ls_sec),
`endif
    .load_new_c (load_new_c),
    .new_ms_hr  (new_ms_hr),
    .new_ls_hr  (new_ls_hr),
    .new_ms_min (new_ms_min),
    .new_ls_min (new_ls_min),
    .ms_hr      (ms_hr),
    .ls_hr      (ls_hr),
    .ms_min     (ms_min),
    .ls_min     (ls_min),
    .day_tick   (day_tick),
    .load_err   (load_err)
  );

  int   checks = 0;
  int   failures = 0;
  int   model_t = 0;    // minutes since midnight
  int   model_sec = 0;
  logic exp_tick = 1'b0;
  logic exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int t);
    int h, m;
    h = t / 60;
    m = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] digits();
    return {ms_hr, ls_hr, ms_min, ls_min};
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, "_time"}, 32'(digits()), 32'(bcd_of(model_t)));
    check_eq({tag, "_tick"}, 32'(day_tick), 32'(exp_tick));
    check_eq({tag, "_err"}, 32'(load_err), 32'(exp_err));
`ifdef TIME_COUNTER_SECONDS_EN
    check_eq({tag, "_sec"}, 32'({ms_sec, ls_sec}),
             32'({4'(model_sec / 10), 4'(model_sec % 10)}));
`endif
  endtask

  // One clock: drive inputs, advance model by the rules, check the registered result.
  task automatic step(input string tag, input logic ld, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d, input logic om, input logic os);
    int ia, ib, ic, id;
    bit legal;
    load_new_c = ld;
    new_ms_hr  = a;
    new_ls_hr  = b;
    new_ms_min = c;
    new_ls_min = d;
    one_minute = om;
`ifdef TIME_COUNTER_SECONDS_EN
    one_second = os;
`endif
    @(posedge clock);
    #1;
    ia = int'(a); ib = int'(b); ic = int'(c); id = int'(d);
    exp_tick = 1'b0;
    exp_err  = 1'b0;
    if (ld) begin
      legal = (ia <= 9) && (ib <= 9) && (ic <= 5) && (id <= 9) &&
              (ia * 10 + ib <= 23) && (ic * 10 + id <= 59);
      if (legal) model_t = (ia * 10 + ib) * 60 + ic * 10 + id;
      else exp_err = 1'b1;
      model_sec = 0;
    end else if (om) begin
      exp_tick  = (model_t == 1439);
      model_t   = (model_t + 1) % 1440;
      model_sec = 0;
    end else if (os) begin
      model_sec = (model_sec + 1) % 60;
    end
    load_new_c = 1'b0;
    one_minute = 1'b0;
`ifdef TIME_COUNTER_SECONDS_EN
    one_second = 1'b0;
`endif
    check_all(tag);
  endtask

  task automatic hold(input string tag);
    step(tag, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    step(tag, 1'b1, a, b, c, d, 1'b0, 1'b0);
  endtask

  task automatic minute(input string tag);
    step(tag, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #11;
    check_all("reset");
    check_eq("reset_const", 32'(digits()), 32'h0000);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) minute("adv10");
    check_eq("ten_min", 32'(digits()), 32'h0010);

    load("ld1259", 4'd1, 4'd2, 4'd5, 4'd9);
    minute("to1300");
    check_eq("hour_carry", 32'(digits()), 32'h1300);
    load("ld0959", 4'd0, 4'd9, 4'd5, 4'd9);
    minute("to1000");
    check_eq("tens_carry", 32'(digits()), 32'h1000);

    load("ld2359", 4'd2, 4'd3, 4'd5, 4'd9);
    minute("wrap");
    check_eq("wrap_time", 32'(digits()), 32'h0000);
    check_eq("wrap_tick", 32'(day_tick), 32'd1);
    hold("after_wrap");
    check_eq("tick_once", 32'(day_tick), 32'd0);

    load("ld0730", 4'd0, 4'd7, 4'd3, 4'd0);
    load("bad2400", 4'd2, 4'd4, 4'd0, 4'd0);
    check_eq("bad2400_err", 32'(load_err), 32'd1);
    hold("bad2400_h");
    load("bad1260", 4'd1, 4'd2, 4'd6, 4'd0);
    check_eq("bad1260_err", 32'(load_err), 32'd1);
    hold("bad1260_h");
    load("bad0a00", 4'd0, 4'hA, 4'd0, 4'd0);
    check_eq("bad0a00_err", 32'(load_err), 32'd1);
    check_eq("bad_keep", 32'(digits()), 32'h0730);
    hold("bad0a00_h");
    check_eq("err_once", 32'(load_err), 32'd0);

    step("ld_and_min", 1'b1, 4'd0, 4'd5, 4'd0, 4'd5, 1'b1, 1'b0);
    check_eq("drop_min", 32'(digits()), 32'h0505);
    for (int i = 0; i < 60; i++) minute("b2b");
    check_eq("b2b_60", 32'(digits()), 32'h0605);

    load("ld1542", 4'd1, 4'd5, 4'd4, 4'd2);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst", 32'(digits()), 32'h0000);
    model_t = 0; model_sec = 0; exp_tick = 1'b0; exp_err = 1'b0;
    check_all("async_rst");
    #2 reset = 1'b1;

`ifdef TIME_COUNTER_SECONDS_EN
    load("ld1000", 4'd1, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 59; i++) step("sec", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check_eq("sec59", 32'({ms_sec, ls_sec}), 32'h59);
    step("sec_wrap", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check_eq("sec_wrap_s", 32'({ms_sec, ls_sec}), 32'h00);
    check_eq("sec_wrap_m", 32'(digits()), 32'h1000);
    step("sec_p", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    step("min_sec", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    check_eq("min_sec_s", 32'({ms_sec, ls_sec}), 32'h00);
    check_eq("min_sec_m", 32'(digits()), 32'h1001);
`endif

    for (int i = 0; i < 400; i++) begin
      logic       ld, om, os;
      logic [3:0] a, b, c, d;
      int         h, m;
      ld = ($urandom_range(0, 9) == 0);
      om = ($urandom_range(0, 1) == 1);
      os = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        c = 4'($urandom_range(0, 15));
        d = 4'($urandom_range(0, 15));
      end else begin
        h = ($urandom_range(0, 2) == 0) ? 23 : $urandom_range(0, 23);
        m = ($urandom_range(0, 2) == 0) ? $urandom_range(55, 59) : $urandom_range(0, 59);
        a = 4'(h / 10);
        b = 4'(h % 10);
        c = 4'(m / 10);
        d = 4'(m % 10);
      end
      step("rand", ld, a, b, c, d, om, os);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
